// File: rtl/mac32_dot_sequencer.sv
// Issue-side sequencer that feeds a 2-stage FP MAC to compute init + sum(b_k*c_k).
// Two lane accumulators alternate so that every element can issue back-to-back.
module mac32_dot_sequencer #(
  parameter int LEN_W   = 16,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      init_i,
  input  logic [1:0]       fp_mode_i,
  input  logic [2:0]       rm_i,
  output logic             busy_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      b_i,
  input  logic [31:0]      c_i,
  output logic [1:0]       mac_fp_mode_o,
  output logic [2:0]       mac_rm_o,
  output logic [31:0]      mac_a_o,
  output logic [31:0]      mac_b_o,
  output logic [31:0]      mac_c_o,
  input  logic [31:0]      mac_result_i,
  input  logic             mac_nv_i,
  input  logic             mac_of_i,
  input  logic             mac_uf_i,
  input  logic             mac_nx_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_result_o,
  output logic [3:0]       out_flags_o
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_COMBINE, S_WAIT, S_OUT} state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, issued_q, issued_d;
  logic [31:0]        acc0_q, acc0_d, acc1_q, acc1_d;
  logic               lane_q, lane_d;
  logic [MAC_LAT-1:0] tok_v_q, tok_v_d, tok_l_q, tok_l_d;
  logic [3:0]         flags_q, flags_d;
  logic [1:0]         fp_mode_q, fp_mode_d;
  logic [2:0]         rm_q, rm_d;
  logic               busy_q, busy_d, out_valid_q, out_valid_d;
  logic [31:0]        out_result_q, out_result_d;
  logic [3:0]         out_flags_q, out_flags_d;

  logic [3:0]  mac_flags;
  logic        res_here;
  logic [31:0] res_fmt, init_fmt, one_c;

  assign mac_flags = {mac_nv_i, mac_of_i, mac_uf_i, mac_nx_i};
  assign res_here  = tok_v_q[MAC_LAT-1];
  assign res_fmt   = (fp_mode_q == 2'b01) ? {16'h0, mac_result_i[15:0]} : mac_result_i;
  assign init_fmt  = (fp_mode_i == 2'b01) ? {16'h0, init_i[15:0]} : init_i;
  assign one_c     = (fp_mode_q == 2'b00) ? 32'h3F80_0000 : 32'h0000_3C00;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    issued_d     = issued_q;
    acc0_d       = acc0_q;
    acc1_d       = acc1_q;
    lane_d       = lane_q;
    flags_d      = flags_q;
    fp_mode_d    = fp_mode_q;
    rm_d         = rm_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    tok_v_d      = {tok_v_q[MAC_LAT-2:0], 1'b0};
    tok_l_d      = {tok_l_q[MAC_LAT-2:0], lane_q};
    in_ready_o   = 1'b0;
    mac_a_o      = 32'h0;
    mac_b_o      = 32'h0;
    mac_c_o      = 32'h0;

    // A token leaving the pipe writes its lane back and contributes its flags.
    if (res_here) begin
      if (tok_l_q[MAC_LAT-1]) acc1_d = mac_result_i;
      else                    acc0_d = mac_result_i;
      flags_d = flags_q | mac_flags;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d     = len_i;
          fp_mode_d = fp_mode_i;
          rm_d      = rm_i;
          acc0_d    = init_fmt;
          acc1_d    = 32'h0;
          flags_d   = 4'h0;
          lane_d    = 1'b0;
          issued_d  = '0;
          if (len_i == '0) begin
            state_d      = S_OUT;
            out_result_d = init_fmt;
            out_flags_d  = 4'h0;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        in_ready_o = !(tok_v_q[0] && (tok_l_q[0] == lane_q)) && (issued_q < len_q);
        if (in_valid_i && in_ready_o) begin
          // Forward a result landing this cycle so the lane never reads a stale value.
          mac_a_o    = (res_here && (tok_l_q[MAC_LAT-1] == lane_q)) ? mac_result_i
                     : (lane_q ? acc1_q : acc0_q);
          mac_b_o    = b_i;
          mac_c_o    = c_i;
          tok_v_d[0] = 1'b1;
          lane_d     = ~lane_q;
          issued_d   = issued_q + CNT_ONE;
          if (issued_d == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (tok_v_q == '0) state_d = S_COMBINE;
      end
      S_COMBINE: begin
        mac_a_o    = acc0_q;
        mac_b_o    = acc1_q;
        mac_c_o    = one_c;
        tok_v_d[0] = 1'b1;
        tok_l_d[0] = 1'b0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (res_here) begin
          out_result_d = res_fmt;
          out_flags_d  = flags_q | mac_flags;
          state_d      = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          state_d   = S_IDLE;
          fp_mode_d = 2'b00;
          rm_d      = 3'b000;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      acc0_q       <= 32'h0;
      acc1_q       <= 32'h0;
      lane_q       <= 1'b0;
      tok_v_q      <= '0;
      tok_l_q      <= '0;
      flags_q      <= 4'h0;
      fp_mode_q    <= 2'b00;
      rm_q         <= 3'b000;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'h0;
      out_flags_q  <= 4'h0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      acc0_q       <= acc0_d;
      acc1_q       <= acc1_d;
      lane_q       <= lane_d;
      tok_v_q      <= tok_v_d;
      tok_l_q      <= tok_l_d;
      flags_q      <= flags_d;
      fp_mode_q    <= fp_mode_d;
      rm_q         <= rm_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign busy_o        = busy_q;
  assign out_valid_o   = out_valid_q;
  assign out_result_o  = out_result_q;
  assign out_flags_o   = out_flags_q;
  assign mac_fp_mode_o = fp_mode_q;
  assign mac_rm_o      = rm_q;

endmodule

// File: tb/tb_mac32_dot_sequencer.sv
// Directed bench for mac32_dot_sequencer with a table-driven 2-cycle MAC model
// holding hand-computed results for every operand triple the jobs produce.
module tb_mac32_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] len_i = '0;
  logic [31:0] init_i = '0;
  logic [1:0]  fp_mode_i = '0;
  logic [2:0]  rm_i = '0;
  logic        busy_o;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] b_i = '0, c_i = '0;
  logic [1:0]  mac_fp_mode_o;
  logic [2:0]  mac_rm_o;
  logic [31:0] mac_a_o, mac_b_o, mac_c_o;
  logic [31:0] mac_result_i;
  logic        mac_nv_i, mac_of_i, mac_uf_i, mac_nx_i;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_result_o;
  logic [3:0]  out_flags_o;

  int compared = 0;
  int mismatched = 0;

  mac32_dot_sequencer #(.LEN_W(16), .MAC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i), .init_i(init_i),
    .fp_mode_i(fp_mode_i), .rm_i(rm_i), .busy_o(busy_o), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .b_i(b_i), .c_i(c_i), .mac_fp_mode_o(mac_fp_mode_o),
    .mac_rm_o(mac_rm_o), .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_c_o(mac_c_o),
    .mac_result_i(mac_result_i), .mac_nv_i(mac_nv_i), .mac_of_i(mac_of_i),
    .mac_uf_i(mac_uf_i), .mac_nx_i(mac_nx_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_result_o(out_result_o), .out_flags_o(out_flags_o)
  );

  always #5 clk = ~clk;

  // Returns {unknown, {NV,OF,UF,NX}, result} for A + B*C.
  function automatic logic [36:0] mac_lookup(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
    case ({a, b, c})
      {32'h0, 32'h0, 32'h0}:                         return {1'b0, 4'h0, 32'h0};
      {32'h3F800000, 32'h40000000, 32'h40400000}:    return {1'b0, 4'h0, 32'h40E00000};
      {32'h00000000, 32'h40000000, 32'h40400000}:    return {1'b0, 4'h0, 32'h40C00000};
      {32'h40E00000, 32'h40000000, 32'h40400000}:    return {1'b0, 4'h0, 32'h41500000};
      {32'h41500000, 32'h40C00000, 32'h3F800000}:    return {1'b0, 4'h0, 32'h41980000};
      {32'h00003C00, 32'h00004000, 32'h00004200}:    return {1'b0, 4'h0, 32'h00004700};
      {32'h00000000, 32'h00004000, 32'h00004200}:    return {1'b0, 4'h0, 32'h00004600};
      {32'h00004700, 32'h00004600, 32'h00003C00}:    return {1'b0, 4'h0, 32'h00004A80};
      {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h40000000}:    return {1'b0, 4'b0101, 32'h7F800000};
      {32'h7F800000, 32'h00000000, 32'h3F800000}:    return {1'b0, 4'h0, 32'h7F800000};
      default:                                       return {1'b1, 4'h0, 32'h0};
    endcase
  endfunction

  logic [36:0] mac_now;
  logic [36:0] mac_p1 = '0, mac_p2 = '0;
  logic        bad_op = 1'b0;
  int          mac_busy_cycles = 0;

  assign mac_now = mac_lookup(mac_a_o, mac_b_o, mac_c_o);
  assign mac_result_i = mac_p2[31:0];
  assign {mac_nv_i, mac_of_i, mac_uf_i, mac_nx_i} = mac_p2[35:32];

  always @(posedge clk) begin
    mac_p1 <= mac_now;
    mac_p2 <= mac_p1;
    if (mac_now[36]) bad_op <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int issued;

  initial begin
    #1;
    check_output("reset_busy", busy_o, 0);
    check_output("reset_valid", out_valid_o, 0);
    check_output("reset_ready", in_ready_o, 0);
    check_output("reset_result", out_result_o, 0);
    check_output("reset_flags", out_flags_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // fp32 job, elements back-to-back, latency-checked cycle by cycle
    start_i = 1; len_i = 3; init_i = 32'h3F800000; fp_mode_i = 2'b00; rm_i = 3'b000;
    in_valid_i = 1; b_i = 32'h40000000; c_i = 32'h40400000;
    check_output("c0_idle_ready", in_ready_o, 0);
    tick(); start_i = 0;
    check_output("c1_ready", in_ready_o, 1);
    check_output("c1_busy", busy_o, 1);
    check_output("c1_mac_a", mac_a_o, 32'h3F800000);
    check_output("c1_mac_b", mac_b_o, 32'h40000000);
    tick();
    check_output("c2_mac_a_lane1", mac_a_o, 32'h0);
    tick();
    check_output("c3_mac_a_bypass", mac_a_o, 32'h40E00000);
    tick();
    check_output("c4_ready_done", in_ready_o, 0);
    check_output("c4_mac_a_idle", mac_a_o, 32'h0);
    tick(); tick(); tick();
    check_output("c7_comb_a", mac_a_o, 32'h41500000);
    check_output("c7_comb_b", mac_b_o, 32'h40C00000);
    check_output("c7_comb_c", mac_c_o, 32'h3F800000);
    tick(); tick();
    check_output("c9_not_valid", out_valid_o, 0);
    tick();
    check_output("c10_valid", out_valid_o, 1);
    check_output("fp32_result", out_result_o, 32'h41980000);
    check_output("fp32_flags", out_flags_o, 4'h0);
    out_ready_i = 1;
    tick(); out_ready_i = 0;
    check_output("fp32_drop_valid", out_valid_o, 0);
    check_output("fp32_idle", busy_o, 0);

    // same job with in_valid toggling every cycle
    start_i = 1; in_valid_i = 0;
    tick(); start_i = 0;
    issued = 0;
    for (int k = 0; k < 60 && out_valid_o !== 1'b1; k++) begin
      in_valid_i = (k % 2 == 0);
      if (busy_o && issued < 3) check_output("stall_ready", in_ready_o, 1);
      if (in_valid_i && in_ready_o) issued++;
      tick();
    end
    check_output("stall_issued", issued, 3);
    check_output("stall_valid", out_valid_o, 1);
    check_output("stall_result", out_result_o, 32'h41980000);
    check_output("stall_flags", out_flags_o, 4'h0);
    out_ready_i = 1;
    tick(); out_ready_i = 0;

    // fp16 job
    start_i = 1; len_i = 2; init_i = 32'h00003C00; fp_mode_i = 2'b01; rm_i = 3'b001;
    in_valid_i = 1; b_i = 32'h00004000; c_i = 32'h00004200;
    tick(); start_i = 0;
    check_output("fp16_mac_mode", mac_fp_mode_o, 2'b01);
    check_output("fp16_mac_rm", mac_rm_o, 3'b001);
    for (int k = 0; k < 30 && out_valid_o !== 1'b1; k++) tick();
    check_output("fp16_valid", out_valid_o, 1);
    check_output("fp16_result", out_result_o, 32'h00004A80);
    check_output("fp16_flags", out_flags_o, 4'h0);
    out_ready_i = 1;
    tick(); out_ready_i = 0;

    // len 0 bypass, then backpressure with start_i hammered
    start_i = 1; len_i = 0; init_i = 32'h40490FDB; fp_mode_i = 2'b00; rm_i = 3'b000;
    in_valid_i = 1; b_i = 32'h11111111; c_i = 32'h22222222;
    mac_busy_cycles = 0;
    tick();
    check_output("len0_valid_c1", out_valid_o, 1);
    check_output("len0_result", out_result_o, 32'h40490FDB);
    check_output("len0_flags", out_flags_o, 4'h0);
    check_output("len0_ready", in_ready_o, 0);
    len_i = 5; init_i = 32'h12345678;
    for (int k = 0; k < 5; k++) begin
      if ((mac_a_o | mac_b_o | mac_c_o) != 32'h0) mac_busy_cycles++;
      tick();
      check_output("bp_valid", out_valid_o, 1);
      check_output("bp_result", out_result_o, 32'h40490FDB);
      check_output("bp_busy", busy_o, 1);
    end
    check_output("len0_no_mac", mac_busy_cycles, 0);
    start_i = 0; out_ready_i = 1;
    tick(); out_ready_i = 0;
    check_output("bp_drop_valid", out_valid_o, 0);
    check_output("bp_idle", busy_o, 0);

    // reset in the middle of RUN
    start_i = 1; len_i = 3; init_i = 32'h3F800000; fp_mode_i = 2'b00; rm_i = 3'b010;
    in_valid_i = 1; b_i = 32'h40000000; c_i = 32'h40400000;
    tick(); start_i = 0;
    check_output("mid_rm", mac_rm_o, 3'b010);
    tick();
    rst_n = 0;
    #1;
    check_output("rst_busy", busy_o, 0);
    check_output("rst_ready", in_ready_o, 0);
    check_output("rst_mac_a", mac_a_o, 0);
    check_output("rst_mac_b", mac_b_o, 0);
    check_output("rst_rm", mac_rm_o, 0);
    check_output("rst_valid", out_valid_o, 0);
    tick();
    rst_n = 1; in_valid_i = 0;
    tick(); tick(); tick();
    check_output("post_rst_idle", busy_o, 0);
    check_output("post_rst_valid", out_valid_o, 0);

    // overflow job
    start_i = 1; len_i = 1; init_i = 32'h7F7FFFFF; fp_mode_i = 2'b00; rm_i = 3'b000;
    in_valid_i = 1; b_i = 32'h7F7FFFFF; c_i = 32'h40000000;
    tick(); start_i = 0;
    for (int k = 0; k < 30 && out_valid_o !== 1'b1; k++) tick();
    check_output("of_valid", out_valid_o, 1);
    check_output("of_result", out_result_o, 32'h7F800000);
    check_output("of_flags", out_flags_o, 4'b0101);
    out_ready_i = 1;
    tick(); out_ready_i = 0; in_valid_i = 0;

    check_output("mac_ops_known", bad_op, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
